// File: rtl/sample_window_collector_if.sv
// Sample-in / window-out bundle: serial samples with valid/ready on one side,
// the parallel 8-sample window with its shift amount and consume counter on the other.
interface sample_window_collector_if #(
    parameter int DATAWIDTH = 16,
    parameter int SAWIDTH   = 8
);
    logic [DATAWIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 sa_load;
    logic [SAWIDTH-1:0]   sa_in;
    logic [DATAWIDTH-1:0] a, b, c, d, e, f, g, h;
    logic [SAWIDTH-1:0]   sa;
    logic                 win_valid;
    logic                 win_ready;
    logic [15:0]          win_count;

    modport master (
        output in_data, in_valid, sa_load, sa_in, win_ready,
        input  in_ready, a, b, c, d, e, f, g, h, sa, win_valid, win_count
    );

    modport slave (
        input  in_data, in_valid, sa_load, sa_in, win_ready,
        output in_ready, a, b, c, d, e, f, g, h, sa, win_valid, win_count
    );
endinterface

// File: rtl/sample_window_collector.sv
// Groups serial samples into double-buffered 8-sample windows; window visible 1 cycle after the 8th accept.
// Backpressure: in_ready drops only when staging is full and the previous window is still held.
module sample_window_collector #(
    parameter int DATAWIDTH     = 16,
    parameter int SAWIDTH       = 8,
    parameter int SHIFT_DEFAULT = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    sample_window_collector_if.slave   bus
);
    localparam logic [SAWIDTH-1:0] SA_RST = SAWIDTH'(SHIFT_DEFAULT);

    logic [2:0]           cnt_q, cnt_d;
    logic [DATAWIDTH-1:0] stage_q [7];
    logic [DATAWIDTH-1:0] stage_d [7];
    logic [DATAWIDTH-1:0] win_q [8];
    logic [DATAWIDTH-1:0] win_d [8];
    logic [SAWIDTH-1:0]   sa_q, sa_d, sa_sh_q, sa_sh_d;
    logic                 win_valid_q, win_valid_d;
    logic [15:0]          win_count_q, win_count_d;
    logic                 in_ready, acc, last;

    // Depends only on registered state (and reset), never on win_ready.
    assign in_ready = ~rst_i & ~((cnt_q == 3'd7) & win_valid_q);
    assign acc      = bus.in_valid & in_ready;
    assign last     = acc & (cnt_q == 3'd7);

    always_comb begin
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        win_d       = win_q;
        sa_d        = sa_q;
        sa_sh_d     = sa_sh_q;
        win_valid_d = win_valid_q;
        win_count_d = win_count_q;

        if (bus.sa_load) begin
            sa_sh_d = bus.sa_in;
        end

        if (last) begin
            for (int i = 0; i < 7; i++) begin
                win_d[i] = stage_q[i];
            end
            win_d[7]    = bus.in_data;
            // A load in the capture cycle binds straight to this window.
            sa_d        = bus.sa_load ? bus.sa_in : sa_sh_q;
            win_valid_d = 1'b1;
            cnt_d       = 3'd0;
        end else begin
            if (acc) begin
                stage_d[cnt_q] = bus.in_data;
                cnt_d          = cnt_q + 3'd1;
            end
            if (win_valid_q & bus.win_ready) begin
                win_valid_d = 1'b0;
                win_count_d = win_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= 3'd0;
            for (int i = 0; i < 7; i++) begin
                stage_q[i] <= '0;
            end
            for (int i = 0; i < 8; i++) begin
                win_q[i] <= '0;
            end
            sa_q        <= SA_RST;
            sa_sh_q     <= SA_RST;
            win_valid_q <= 1'b0;
            win_count_q <= 16'd0;
        end else begin
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            win_q       <= win_d;
            sa_q        <= sa_d;
            sa_sh_q     <= sa_sh_d;
            win_valid_q <= win_valid_d;
            win_count_q <= win_count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.a         = win_q[0];
    assign bus.b         = win_q[1];
    assign bus.c         = win_q[2];
    assign bus.d         = win_q[3];
    assign bus.e         = win_q[4];
    assign bus.f         = win_q[5];
    assign bus.g         = win_q[6];
    assign bus.h         = win_q[7];
    assign bus.sa        = sa_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win_count = win_count_q;
endmodule

// File: tb/tb_sample_window_collector.sv
// Randomized bench for sample_window_collector against a queue-based window model,
// with literal checks on reset, stall, shift binding and counter wrap.
module tb_sample_window_collector;
    localparam int DW = 16;
    localparam int SW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sample_window_collector_if #(.DATAWIDTH(DW), .SAWIDTH(SW)) bus ();

    sample_window_collector #(
        .DATAWIDTH(DW), .SAWIDTH(SW), .SHIFT_DEFAULT(1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: samples accepted since the last window, the window being shown, its sa.
    logic [DW-1:0] pend [$];
    logic [DW-1:0] m_win [8];
    logic [SW-1:0] m_sa, m_sh;
    logic          m_valid;
    logic [15:0]   m_count;

    task automatic model_step();
        bit rdy;
        bit hs;
        if (rst) begin
            pend.delete();
            for (int i = 0; i < 8; i++) m_win[i] = '0;
            m_valid = 1'b0;
            m_count = 16'd0;
            m_sa    = SW'(1);
            m_sh    = SW'(1);
        end else begin
            rdy = !(pend.size() == 7 && m_valid);
            hs  = m_valid && bus.win_ready && !(bus.in_valid && rdy && pend.size() == 7);
            if (hs) begin
                m_valid = 1'b0;
                m_count = m_count + 16'd1;
            end
            if (bus.in_valid && rdy) begin
                pend.push_back(bus.in_data);
                if (pend.size() == 8) begin
                    for (int i = 0; i < 8; i++) m_win[i] = pend[i];
                    m_sa    = bus.sa_load ? bus.sa_in : m_sh;
                    m_valid = 1'b1;
                    pend.delete();
                end
            end
            if (bus.sa_load) m_sh = bus.sa_in;
        end
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic compare();
        chk("in_ready", 128'(bus.in_ready), 128'(!rst && !(pend.size() == 7 && m_valid)));
        chk("win_valid", 128'(bus.win_valid), 128'(m_valid));
        chk("win_count", 128'(bus.win_count), 128'(m_count));
        chk("sa", 128'(bus.sa), 128'(m_sa));
        chk("window", {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h},
            {m_win[0], m_win[1], m_win[2], m_win[3], m_win[4], m_win[5], m_win[6], m_win[7]});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic send(input logic [DW-1:0] dat);
        int  n    = 0;
        bit  done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = dat;
        while (!done && n < 40) begin
            done = bus.in_ready;
            cycle();
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: sample %0h not accepted, required acceptance within 40 cycles", dat);
        end
    endtask

    task automatic consume();
        bus.in_valid  = 1'b0;
        bus.win_ready = 1'b1;
        cycle();
        bus.win_ready = 1'b0;
    endtask

    initial begin
        int k, n;
        bit r;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.sa_load   = 1'b0;
        bus.sa_in     = '0;
        bus.win_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Basic window
        for (int i = 1; i <= 8; i++) send(DW'(i));
        bus.in_valid = 1'b0;
        chk("t2_a", 128'(bus.a), 128'd1);
        chk("t2_h", 128'(bus.h), 128'd8);
        chk("t2_valid", 128'(bus.win_valid), 128'd1);
        chk("t2_sa", 128'(bus.sa), 128'd1);
        consume();
        chk("t2_valid_drop", 128'(bus.win_valid), 128'd0);
        chk("t2_count", 128'(bus.win_count), 128'd1);

        // Stall: staging full while a window is held
        for (int i = 101; i <= 108; i++) send(DW'(i));
        for (int i = 9; i <= 15; i++) send(DW'(i));
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(16);
        repeat (3) cycle();
        chk("t3_stall_rdy", 128'(bus.in_ready), 128'd0);
        chk("t3_held_a", 128'(bus.a), 128'd101);
        chk("t3_held_h", 128'(bus.h), 128'd108);
        bus.win_ready = 1'b1;
        cycle();
        bus.win_ready = 1'b0;
        chk("t3_hs_valid", 128'(bus.win_valid), 128'd0);
        chk("t3_rdy_back", 128'(bus.in_ready), 128'd1);
        cycle();
        bus.in_valid = 1'b0;
        chk("t3_a", 128'(bus.a), 128'd9);
        chk("t3_g", 128'(bus.g), 128'd15);
        chk("t3_h", 128'(bus.h), 128'd16);
        chk("t3_valid", 128'(bus.win_valid), 128'd1);
        consume();

        // Shift binding
        for (int i = 21; i <= 28; i++) send(DW'(i));
        bus.in_valid = 1'b0;
        bus.sa_load  = 1'b1;
        bus.sa_in    = SW'(3);
        cycle();
        bus.sa_load  = 1'b0;
        chk("t4_sa_held", 128'(bus.sa), 128'd1);
        consume();
        for (int i = 31; i <= 38; i++) send(DW'(i));
        bus.in_valid = 1'b0;
        chk("t4_sa_next", 128'(bus.sa), 128'd3);
        consume();
        for (int i = 41; i <= 47; i++) send(DW'(i));
        bus.sa_load = 1'b1;
        bus.sa_in   = SW'(5);
        send(DW'(48));
        bus.sa_load  = 1'b0;
        bus.in_valid = 1'b0;
        chk("t4_sa_same_cycle", 128'(bus.sa), 128'd5);
        consume();

        // Reset mid-fill
        for (int i = 51; i <= 55; i++) send(DW'(i));
        bus.in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        chk("t1_rdy_in_rst", 128'(bus.in_ready), 128'd0);
        chk("t1_valid", 128'(bus.win_valid), 128'd0);
        chk("t1_win", {bus.a, bus.h}, 128'd0);
        chk("t1_count", 128'(bus.win_count), 128'd0);
        chk("t1_sa", 128'(bus.sa), 128'd1);
        cycle();
        rst = 1'b0;
        cycle();
        for (int i = 61; i <= 68; i++) send(DW'(i));
        bus.in_valid = 1'b0;
        chk("t1_after_a", 128'(bus.a), 128'd61);
        chk("t1_after_h", 128'(bus.h), 128'd68);
        consume();

        // Gapped random input, consumer always ready: 100 windows
        bus.win_ready = 1'b1;
        k = 0;
        n = 0;
        while (k < 800 && n < 4000) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data  = DW'($urandom);
            r = bus.in_ready;
            cycle();
            if (bus.in_valid && r) k++;
            n++;
        end
        if (k < 800) begin
            checks++;
            errors++;
            $display("FAIL t5_timeout: accepted %0d samples, required 800", k);
        end
        bus.in_valid = 1'b0;
        cycle();
        cycle();
        chk("t5_count", 128'(bus.win_count), 128'd101);

        // Random input gaps and random consumer stalls, with sa reloads
        k = 0;
        n = 0;
        while (k < 240 && n < 4000) begin
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.in_data   = DW'($urandom);
            bus.win_ready = ($urandom_range(0, 4) == 0);
            bus.sa_load   = ($urandom_range(0, 9) == 0);
            bus.sa_in     = SW'($urandom);
            r = bus.in_ready;
            cycle();
            if (bus.in_valid && r) k++;
            n++;
        end
        if (k < 240) begin
            checks++;
            errors++;
            $display("FAIL t5b_timeout: accepted %0d samples, required 240", k);
        end
        bus.sa_load = 1'b0;
        consume();

        // Counter wrap and extreme sample values
        force dut.win_count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        #1;
        release dut.win_count_q;
        cycle();
        chk("t6_preset", 128'(bus.win_count), 128'hFFFF);
        for (int i = 0; i < 8; i++) send((i % 2 == 1) ? 16'hFFFF : 16'h0000);
        bus.in_valid = 1'b0;
        chk("t6_a", 128'(bus.a), 128'h0000);
        chk("t6_b", 128'(bus.b), 128'hFFFF);
        chk("t6_h", 128'(bus.h), 128'hFFFF);
        consume();
        chk("t6_wrap", 128'(bus.win_count), 128'h0000);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
